// File: rtl/byte_decode_stream_pkg.sv
// Shared constants and types for the streaming ByteDecode_d unit.
// Holds the polynomial size, the modulus and the FSM state type.
package byte_decode_stream_pkg;

    localparam int N = 256;
    localparam int Q = 3329;

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    function automatic int bytes_per_poly(input int d);
        return 32 * d;
    endfunction

endpackage

// File: rtl/byte_decode_stream_coef_mod_q.sv
// Conditional subtract-Q for 12-bit raw coefficients.
// Purely combinational; flags raw values at or above Q.
module coef_mod_q
    import byte_decode_stream_pkg::*;
(
    input  logic [11:0] raw_i,
    output logic [11:0] coef_o,
    output logic        over_o
);

    localparam logic [11:0] QV = 12'(Q);

    always_comb begin
        over_o = (raw_i >= QV);
        coef_o = over_o ? (raw_i - QV) : raw_i;
    end

endmodule

// File: rtl/byte_decode_stream.sv
// Streaming ByteDecode_d: packs LSB-first bytes into D-bit coefficients.
// A D+7 bit buffer lets a byte be appended in the same cycle as an extract.
module byte_decode_stream
    import byte_decode_stream_pkg::*;
#(
    parameter int D         = 12,
    parameter int OUT_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear_i,
    input  logic [7:0]           byte_i,
    input  logic                 byte_valid_i,
    output logic                 byte_ready_o,
    output logic [OUT_WIDTH-1:0] coef_o,
    output logic                 coef_valid_o,
    input  logic                 coef_ready_i,
    output logic                 coef_last_o,
    output logic                 mod_err_o
);

    localparam int BW = D + 7;
    localparam int NB = bytes_per_poly(D);

    localparam logic [4:0] D_C   = 5'(D);
    localparam logic [4:0] D2_C  = 5'(2 * D);
    localparam logic [8:0] NB_L  = 9'(NB - 1);
    localparam logic [8:0] N_C   = 9'(N);
    localparam logic [8:0] LASTI = 9'(N - 1);

    logic [BW-1:0]        bits_q;
    logic [4:0]           cnt_q;
    logic [8:0]           nbyte_q;
    logic [8:0]           nload_q;
    state_t               state_q;
    logic                 live_q;
    logic [OUT_WIDTH-1:0] coef_q;
    logic                 valid_q;
    logic                 last_q;
    logic                 err_q;

    logic          can_load;
    logic          extract;
    logic          byte_ready;
    logic          accept;
    logic          handshake;
    logic          last_hs;
    logic [BW-1:0] shifted;
    logic [BW-1:0] appended;
    logic [BW-1:0] bits_d;
    logic [4:0]    base;
    logic [4:0]    cnt_d;
    logic [D-1:0]  raw;
    logic [D-1:0]  red;
    logic          over;

    assign can_load = !valid_q || coef_ready_i;
    assign extract  = !clear_i && (cnt_q >= D_C) && can_load
                      && (nload_q < N_C);

    // Ready reaches coef_ready_i only via extract.
    assign byte_ready = live_q && !clear_i && (state_q == FILL)
                        && ((cnt_q < D_C)
                            || ((cnt_q < D2_C) && extract));
    assign accept    = byte_valid_i && byte_ready;
    assign handshake = valid_q && coef_ready_i;
    assign last_hs   = handshake && last_q;

    always_comb begin
        shifted  = extract ? (bits_q >> D) : bits_q;
        base     = extract ? (cnt_q - D_C) : cnt_q;
        appended = '0;
        if (accept) begin
            appended = BW'(byte_i) << base;
        end
        bits_d = shifted | appended;
        cnt_d  = base + (accept ? 5'd8 : 5'd0);
    end

    assign raw = bits_q[D-1:0];

    generate
        if (D == 12) begin : g_modq
            coef_mod_q u_mod (
                .raw_i  (raw),
                .coef_o (red),
                .over_o (over)
            );
        end else begin : g_plain
            assign red  = raw;
            assign over = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bits_q  <= '0;
            cnt_q   <= '0;
            nbyte_q <= '0;
            nload_q <= '0;
            state_q <= FILL;
            live_q  <= 1'b0;
            coef_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            live_q <= 1'b1;
            if (clear_i) begin
                bits_q  <= '0;
                cnt_q   <= '0;
                nbyte_q <= '0;
                nload_q <= '0;
                state_q <= FILL;
                valid_q <= 1'b0;
                last_q  <= 1'b0;
                err_q   <= 1'b0;
            end else begin
                bits_q <= bits_d;
                cnt_q  <= cnt_d;
                if (accept) begin
                    nbyte_q <= nbyte_q + 9'd1;
                end
                if (extract) begin
                    coef_q  <= OUT_WIDTH'(red);
                    valid_q <= 1'b1;
                    last_q  <= (nload_q == LASTI);
                    err_q   <= over
                               || ((nload_q != 9'd0) && err_q);
                    nload_q <= nload_q + 9'd1;
                end else if (handshake) begin
                    valid_q <= 1'b0;
                    last_q  <= 1'b0;
                end
                unique case (state_q)
                    FILL: begin
                        if (accept && (nbyte_q == NB_L)) begin
                            state_q <= DRAIN;
                        end
                    end
                    DRAIN: begin
                        if (last_hs) begin
                            state_q <= FILL;
                            nbyte_q <= '0;
                            nload_q <= '0;
                        end
                    end
                endcase
            end
        end
    end

    assign byte_ready_o = byte_ready;
    assign coef_o       = coef_q;
    assign coef_valid_o = valid_q;
    assign coef_last_o  = last_q;
    assign mod_err_o    = err_q;

endmodule

// File: tb/tb_byte_decode_stream.sv
// Scoreboard bench for byte_decode_stream at D=8, D=1 and D=12.
// Drivers push expected coefficients; a monitor pops on each handshake.
module tb_byte_decode_stream;

    typedef struct packed {
        logic [15:0] c;
        logic        last;
        logic        chk;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n [3];
    logic        clr   [3];
    logic [7:0]  bdat  [3];
    logic        bval  [3];
    logic        brdy  [3];
    logic [15:0] coef  [3];
    logic        cval  [3];
    logic        cr    [3];
    logic        clast [3];
    logic        merr  [3];

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int hs_n0 = 0;
    int hs_first0 = 0;
    int hs_last0 = 0;

    logic [7:0]  stim [384];
    logic        stall_en = 1'b0;
    logic [15:0] lfsr = 16'hACE1;
    logic        pst [3];
    logic [15:0] pc  [3];
    logic        pl  [3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    byte_decode_stream #(.D(8), .OUT_WIDTH(16)) u_d8 (
        .clk_i(clk), .rst_ni(rst_n[0]), .clear_i(clr[0]),
        .byte_i(bdat[0]), .byte_valid_i(bval[0]),
        .byte_ready_o(brdy[0]), .coef_o(coef[0]),
        .coef_valid_o(cval[0]), .coef_ready_i(cr[0]),
        .coef_last_o(clast[0]), .mod_err_o(merr[0])
    );

    byte_decode_stream #(.D(1), .OUT_WIDTH(16)) u_d1 (
        .clk_i(clk), .rst_ni(rst_n[1]), .clear_i(clr[1]),
        .byte_i(bdat[1]), .byte_valid_i(bval[1]),
        .byte_ready_o(brdy[1]), .coef_o(coef[1]),
        .coef_valid_o(cval[1]), .coef_ready_i(cr[1]),
        .coef_last_o(clast[1]), .mod_err_o(merr[1])
    );

    byte_decode_stream #(.D(12), .OUT_WIDTH(16)) u_d12 (
        .clk_i(clk), .rst_ni(rst_n[2]), .clear_i(clr[2]),
        .byte_i(bdat[2]), .byte_valid_i(bval[2]),
        .byte_ready_o(brdy[2]), .coef_o(coef[2]),
        .coef_valid_o(cval[2]), .coef_ready_i(cr[2]),
        .coef_last_o(clast[2]), .mod_err_o(merr[2])
    );

    function automatic void push(input int k, input int c,
                                 input logic last, input logic chk,
                                 input logic err);
        exp_t e;
        e.c = 16'(c);
        e.last = last;
        e.chk = chk;
        e.err = err;
        case (k)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endfunction

    function automatic int qsize(input int k);
        case (k)
            0: return q0.size();
            1: return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic exp_t pop(input int k);
        case (k)
            0: return q0.pop_front();
            1: return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    function automatic logic [7:0] enc12(input int j);
        logic [7:0] r;
        int p;
        r = '0;
        for (int b = 0; b < 8; b++) begin
            p = 8 * j + b;
            r[b] = 1'((p / 12) >> (p % 12));
        end
        return r;
    endfunction

    // Monitor: scoreboard pop on handshake, hold check during stalls.
    always @(negedge clk) begin
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            if (pst[k]) begin
                checks++;
                if (!(cval[k] && coef[k] == pc[k] && clast[k] == pl[k])) begin
                    errors++;
                    $display("FAIL stall_hold inst%0d: valid %0b coef %0d last %0b, required valid 1 coef %0d last %0b",
                             k, cval[k], coef[k], clast[k], pc[k], pl[k]);
                end
            end
            pst[k] = cval[k] && !cr[k] && !clr[k];
            pc[k] = coef[k];
            pl[k] = clast[k];
            if (cval[k] && cr[k]) begin
                checks++;
                if (qsize(k) == 0) begin
                    errors++;
                    $display("FAIL unexpected_coef inst%0d: got coef %0d, required none", k, coef[k]);
                end else begin
                    e = pop(k);
                    if (coef[k] != e.c || clast[k] != e.last
                        || (e.chk && merr[k] != e.err)) begin
                        errors++;
                        $display("FAIL coef inst%0d: got coef %0d last %0b err %0b, required coef %0d last %0b err %0b",
                                 k, coef[k], clast[k], merr[k], e.c, e.last, e.err);
                    end
                end
                if (k == 0) begin
                    if (hs_n0 == 0) hs_first0 = cyc;
                    hs_last0 = cyc;
                    hs_n0++;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (stall_en) begin
            #1;
            lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            cr[2] = lfsr[0];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, got, want);
        end
    endtask

    task automatic send(input int k, input logic [7:0] b);
        int n;
        logic acc;
        n = 0;
        acc = 1'b0;
        bval[k] = 1'b1;
        bdat[k] = b;
        while (!acc && n < 1000) begin
            @(negedge clk);
            acc = brdy[k];
            tick();
            n++;
        end
        bval[k] = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout inst%0d: byte not accepted, required accept", k);
        end
    endtask

    task automatic send_stream(input int k, input int n);
        for (int i = 0; i < n; i++) send(k, stim[i]);
    endtask

    task automatic wait_drain(input int k, input int budget);
        int n;
        n = 0;
        while (qsize(k) != 0 && n < budget) begin
            tick();
            n++;
        end
        chk($sformatf("drain_inst%0d", k), qsize(k), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] a5;
        a5 = 8'hA5;
        for (int k = 0; k < 3; k++) begin
            rst_n[k] = 1'b0;
            clr[k] = 1'b0;
            bval[k] = 1'b0;
            bdat[k] = 8'h00;
            cr[k] = 1'b1;
            pst[k] = 1'b0;
            pc[k] = '0;
            pl[k] = 1'b0;
        end
        tick();
        tick();
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_valid%0d", k), cval[k], 0);
            chk($sformatf("rst_coef%0d", k), coef[k], 0);
            chk($sformatf("rst_last%0d", k), clast[k], 0);
            chk($sformatf("rst_err%0d", k), merr[k], 0);
            chk($sformatf("rst_ready%0d", k), brdy[k], 0);
        end
        tick();
        for (int k = 0; k < 3; k++) rst_n[k] = 1'b1;
        tick();
        @(negedge clk);
        for (int k = 0; k < 3; k++) chk($sformatf("ready_after_rst%0d", k), brdy[k], 1);
        tick();

        // D=8 counting bytes, full throughput
        hs_n0 = 0;
        for (int i = 0; i < 256; i++) begin
            stim[i] = 8'(i);
            push(0, i, i == 255, i == 255, 1'b0);
        end
        send_stream(0, 256);
        @(negedge clk);
        chk("d8_ready_in_drain", brdy[0], 0);
        wait_drain(0, 100);
        tick();
        @(negedge clk);
        chk("d8_ready_after_last", brdy[0], 1);
        chk("d8_throughput", hs_last0 - hs_first0, 255);
        chk("d8_count", hs_n0, 256);
        tick();

        // D=1, 0xA5 pattern
        for (int i = 0; i < 32; i++) stim[i] = 8'hA5;
        for (int i = 0; i < 256; i++)
            push(1, int'(1'(a5 >> (i % 8))), i == 255, i == 255, 1'b0);
        send_stream(1, 32);
        wait_drain(1, 400);

        // D=12, f[i] = i
        for (int j = 0; j < 384; j++) stim[j] = enc12(j);
        for (int i = 0; i < 256; i++) push(2, i, i == 255, i == 255, 1'b0);
        send_stream(2, 384);
        wait_drain(2, 400);

        // D=12, two over-range raw values
        for (int j = 0; j < 384; j++) stim[j] = (j < 3) ? 8'hFF : 8'h00;
        for (int i = 0; i < 256; i++)
            push(2, (i < 2) ? 766 : 0, i == 255, i == 255, 1'b1);
        send_stream(2, 384);
        wait_drain(2, 400);

        // D=12 with random downstream stalls
        for (int j = 0; j < 384; j++) stim[j] = enc12(j);
        for (int i = 0; i < 256; i++) push(2, i, i == 255, i == 255, 1'b0);
        stall_en = 1'b1;
        send_stream(2, 384);
        wait_drain(2, 4000);
        stall_en = 1'b0;
        tick();
        tick();
        cr[2] = 1'b1;
        tick();

        // D=8 abort by clear after 100 bytes
        for (int i = 0; i < 100; i++) stim[i] = 8'(i) ^ 8'h5A;
        for (int i = 0; i < 99; i++) push(0, int'(stim[i]), 1'b0, 1'b0, 1'b0);
        send_stream(0, 100);
        clr[0] = 1'b1;
        @(negedge clk);
        chk("ready_in_clear", brdy[0], 0);
        tick();
        clr[0] = 1'b0;
        @(negedge clk);
        chk("valid_after_clear", cval[0], 0);
        chk("clear_drained", qsize(0), 0);
        tick();

        // D=8 abort by reset mid-polynomial
        for (int i = 0; i < 50; i++) stim[i] = 8'(i) ^ 8'h3C;
        for (int i = 0; i < 48; i++) push(0, int'(stim[i]), 1'b0, 1'b0, 1'b0);
        send_stream(0, 50);
        rst_n[0] = 1'b0;
        @(negedge clk);
        chk("valid_in_reset", cval[0], 0);
        chk("reset_drained", qsize(0), 0);
        tick();
        rst_n[0] = 1'b1;
        @(negedge clk);
        chk("valid_after_reset", cval[0], 0);
        tick();

        // Full polynomial after the aborts
        for (int i = 0; i < 256; i++) begin
            stim[i] = 8'(255 - i);
            push(0, 255 - i, i == 255, i == 255, 1'b0);
        end
        send_stream(0, 256);
        wait_drain(0, 100);
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
